pending_request_encoder: RTL and testbench
==========================================

Name: pending_request_encoder

Overview:
- Parametrised, registered successor to the team's 16-to-4 one-hot encoder.
- Captures request pulses from WIDTH sources into a pending mask and presents one pending index at a time on a valid/ready output.
- The index is chosen by fixed-priority or round-robin arbitration; its pending bit clears when the consumer accepts it.
- Sits between interrupt/event sources and a single-index consumer, such as a sequencer or a CSR event log.

Parameters:
- WIDTH, 16, number of request sources; legal 2..64, non-power-of-two allowed.
- IDX_W, 4, output index width; must be >= clog2(WIDTH).
- MODE, 0, arbitration: 0 = fixed priority, lowest index wins; 1 = round-robin, search starts at last accepted index + 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, req_in is ignored; pending requests still drain.
- clear  in  1  synchronous flush of pending mask and output register.
- req_in  in  WIDTH  request pulses, one bit per source, OR-ed into pending.
- out_idx  out  IDX_W  index of the presented request.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- pending  out  WIDTH  current pending mask (registered).
- overflow  out  1  one-cycle pulse: a request arrived for a bit already pending.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - pending=0, out_valid=0, out_idx=0, overflow=0.
  - Internal last_idx=WIDTH-1, so the first round-robin search starts at 0.
  - Reset mid-transfer discards everything; no grant completes.
- accept = out_valid && out_ready.
- gmask = one-hot(out_idx) when accept, else 0.
- Pending update each edge: pending <= (pending & ~gmask) | (enable ? req_in : 0).
  - Set wins: a bit granted and re-requested in the same cycle stays pending; no overflow.
- overflow: registered.
  - Asserted for one cycle after any edge where enable && req_in[i] && pending[i] && !gmask[i].
  - The duplicate request is merged; only one grant results.
- Output register loads when !out_valid || accept:
  - cand = pending & ~(out_valid ? one-hot(out_idx) : 0). This uses the registered pending, not same-cycle req_in.
  - If cand==0: out_valid<=0, out_idx<=0.
  - Otherwise: out_valid<=1, out_idx<=selected bit.
    - MODE 0: lowest set bit of cand.
    - MODE 1: first set bit of cand scanning last_idx+1, last_idx+2, … with wrap from WIDTH-1 to 0. On accept the scan starts from the index being accepted + 1.
- Hold rule: while out_valid && !out_ready, out_idx and out_valid are stable. A newly arriving higher-priority request does not preempt.
- last_idx <= out_idx on accept (MODE 1 only; unused in MODE 0).
- Latency: req_in at edge t → pending at t → out_valid at edge t+1 if the output register is free.
- Throughput: with out_ready held 1, one grant per cycle, back-to-back.
- clear=1 (synchronous, overrides req_in and accept):
  - pending<=0, out_valid<=0, out_idx<=0, last_idx<=WIDTH-1.
  - overflow<=0.
- Index arithmetic is unsigned. Bits of out_idx above clog2(WIDTH) are always 0.

Test Plan:
- Reset: MODE 0, pending=16'h00F0 and out_valid=1, drop rst_n asynchronously between edges → pending=0, out_valid=0, out_idx=0, overflow=0 before the next edge; no accept after release.
- Drain order: MODE 0, out_ready=1, req_in=16'h8421 for one cycle → out_idx 0,5,10,15 on four consecutive cycles with out_valid=1, then out_valid=0 and pending=0.
- Backpressure: out_ready=0, out_idx=3 valid, then req_in=16'h0001 → out_idx holds 3 for all stalled cycles. On out_ready=1: accept 3, then out_idx=0 next cycle.
- Round-robin: MODE 1, grant idx 0 (pending empty), then req_in=16'h0003 → out_idx=1 then 0. Same stimulus with MODE 0 → out_idx=0 then 1.
- Overflow and merge: out_ready=0, bit 4 pending, req_in=16'h0010 again → overflow=1 for exactly one cycle; after out_ready=1, exactly one grant of idx 4. Also: accept idx 4 while req_in=16'h0010 in the same cycle → overflow=0 and idx 4 is granted a second time.
- Enable/clear: enable=0 with req_in=16'hFFFF → pending unchanged. Then clear=1 with req_in=16'h0001 and enable=1 → pending=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/pending_request_encoder_if.sv
// ---------------------------------------------------------------------------
// pending_request_encoder_if
//
// Purpose: valid/ready channel that carries one selected request index from
// the pending request encoder to its single consumer.
//
// Signals:
//   out_idx   - index of the presented request (IDX_W bits)
//   out_valid - out_idx is valid
//   out_ready - consumer accepts when out_valid && out_ready
//
// Modports:
//   master - the encoder side: drives out_idx/out_valid, samples out_ready
//   slave  - the consumer side: samples out_idx/out_valid, drives out_ready
// ---------------------------------------------------------------------------
interface pending_request_encoder_if #(
  parameter int IDX_W = 4
);

  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_idx,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/pending_request_encoder.sv
// ---------------------------------------------------------------------------
// pending_request_encoder
//
// Purpose: collects request pulses from WIDTH sources into a pending mask and
// hands out one pending index at a time over a valid/ready channel. The index
// is picked by fixed priority (MODE 0, lowest index wins) or round-robin
// (MODE 1, search starts one past the last accepted index). A pending bit is
// cleared when the consumer accepts its index.
//
// Parameters:
//   WIDTH - number of request sources, 2..64 (non-power-of-two allowed)
//   IDX_W - output index width, must be >= clog2(WIDTH)
//   MODE  - 0 = fixed priority, 1 = round-robin
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   enable   - when 0, req_in is ignored; pending requests still drain
//   clear    - synchronous flush of pending mask, output register and
//              round-robin pointer; overrides req_in and accept
//   req_in   - request pulses, one bit per source, OR-ed into pending
//   grant    - valid/ready output channel (out_idx, out_valid, out_ready)
//   pending  - current registered pending mask
//   overflow - one-cycle pulse: a request arrived for a bit already pending
//              that was not being granted in the same cycle
// ---------------------------------------------------------------------------
module pending_request_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter int MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          req_in,
  pending_request_encoder_if.master grant,
  output logic [WIDTH-1:0]          pending,
  output logic                      overflow
);

  // Width of an index that can address every source. Any out_idx bits above
  // this are tied to zero.
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Round-robin pointer value that makes the next search start at index 0.
  localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(WIDTH - 1);

  // Registered output channel state and round-robin pointer.
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic [SEL_W-1:0] last_q;

  // Combinational helpers.
  logic             accept;
  logic [WIDTH-1:0] req_eff;
  logic [WIDTH-1:0] held_mask;
  logic [WIDTH-1:0] gmask;
  logic [WIDTH-1:0] pending_next;
  logic             overflow_next;
  logic [WIDTH-1:0] cand;
  logic [SEL_W-1:0] scan_base;
  logic [SEL_W-1:0] scan_start;
  logic [WIDTH-1:0] upper_mask;
  logic [WIDTH-1:0] upper_cand;
  logic [SEL_W-1:0] pick;

  // One-hot decode of an index into a WIDTH-bit mask.
  function automatic logic [WIDTH-1:0] one_hot(input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] bit0;
    bit0    = '0;
    bit0[0] = 1'b1;
    return bit0 << idx;
  endfunction

  // Index of the lowest set bit; returns 0 for an all-zero vector, callers
  // only use the result when the vector is non-zero.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [WIDTH-1:0] vec);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res = SEL_W'(i);
      end
    end
    return res;
  endfunction

  // Handshake, pending-mask update and overflow detection. The grant mask is
  // removed before the new requests are OR-ed in, so a source that is
  // granted and re-requests in the same cycle stays pending without being
  // flagged as an overflow.
  always_comb begin
    accept        = valid_q && grant.out_ready;
    req_eff       = enable ? req_in : '0;
    held_mask     = valid_q ? one_hot(sel_q) : '0;
    gmask         = accept ? held_mask : '0;
    pending_next  = (pending & ~gmask) | req_eff;
    overflow_next = |(req_eff & pending & ~gmask);
  end

  // Arbitration. Candidates come from the registered pending mask minus the
  // index currently on the output, so a request arriving this cycle is only
  // eligible one edge later. Round-robin splits the candidates into the part
  // at or above the scan start and takes its lowest bit; if that part is
  // empty the search has wrapped, and the lowest candidate overall wins.
  // When an accept is happening, the scan starts just past the index being
  // accepted because that index becomes the new pointer on this edge.
  always_comb begin
    cand       = pending & ~held_mask;
    scan_base  = accept ? sel_q : last_q;
    scan_start = (scan_base >= LAST_INIT) ? '0 : scan_base + SEL_W'(1);
    upper_mask = ~(one_hot(scan_start) - WIDTH'(1));
    upper_cand = cand & upper_mask;
    pick       = lowest_set(cand);
    if (MODE == 1 && (|upper_cand)) begin
      pick = lowest_set(upper_cand);
    end
  end

  // Pending mask and overflow pulse. Clear flushes everything and also
  // suppresses any overflow indication for the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

  // Output register and round-robin pointer. The output only reloads when it
  // is empty or being accepted, so a stalled index is never preempted by a
  // newly arriving higher-priority request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= LAST_INIT;
    end else if (clear) begin
      valid_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= LAST_INIT;
    end else begin
      if (accept && MODE == 1) begin
        last_q <= sel_q;
      end
      if (!valid_q || accept) begin
        if (|cand) begin
          valid_q <= 1'b1;
          sel_q   <= pick;
        end else begin
          valid_q <= 1'b0;
          sel_q   <= '0;
        end
      end
    end
  end

  assign grant.out_valid = valid_q;
  assign grant.out_idx   = IDX_W'(sel_q);

endmodule

// File: tb/tb_pending_request_encoder.sv
// ---------------------------------------------------------------------------
// tb_pending_request_encoder
//
// Purpose: directed self-checking bench for pending_request_encoder. Two
// instances share all stimulus: dut0 uses fixed priority, dut1 round-robin.
// Inputs change just after a falling edge, outputs are sampled on the
// falling edge, one rising edge in between.
// ---------------------------------------------------------------------------
module tb_pending_request_encoder;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [15:0] req;
  logic        ready;
  logic [15:0] pend0;
  logic [15:0] pend1;
  logic        ovf0;
  logic        ovf1;

  int n_cmp;
  int n_bad;

  pending_request_encoder_if #(.IDX_W(4)) if0 ();
  pending_request_encoder_if #(.IDX_W(4)) if1 ();

  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  pending_request_encoder #(.WIDTH(16), .IDX_W(4), .MODE(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .req_in   (req),
    .grant    (if0),
    .pending  (pend0),
    .overflow (ovf0)
  );

  pending_request_encoder #(.WIDTH(16), .IDX_W(4), .MODE(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .clear    (clear),
    .req_in   (req),
    .grant    (if1),
    .pending  (pend1),
    .overflow (ovf1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, crossing exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Build pending/valid state, then drop reset between edges and confirm
  // the outputs clear at once and nothing is granted after release.
  task automatic test_reset();
    ready = 1'b0; enable = 1'b1; req = 16'h00F0;
    step();
    req = 16'h0000;
    step();
    n_cmp++;
    if (pend0 !== 16'h00F0) begin
      n_bad++; $display("[TB] FAIL reset_pre_pending: got %h, expected 00f0", pend0);
    end
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd4) begin
      n_bad++; $display("[TB] FAIL reset_pre_out: got valid=%b idx=%0d, expected valid=1 idx=4", if0.out_valid, if0.out_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pend0 !== 16'h0000 || pend1 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL reset_pending: got %h/%h, expected 0000/0000", pend0, pend1);
    end
    n_cmp++;
    if (if0.out_valid !== 1'b0 || if0.out_idx !== 4'd0 || if1.out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_out: got valid=%b idx=%0d, expected valid=0 idx=0", if0.out_valid, if0.out_idx);
    end
    n_cmp++;
    if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_overflow: got %b/%b, expected 0/0", ovf0, ovf1);
    end
    ready = 1'b1;
    #1 rst_n = 1'b1;
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL reset_release: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
  endtask

  // One request pulse with four bits drains lowest-first, one per cycle.
  task automatic test_drain();
    int exp_idx [4] = '{0, 5, 10, 15};
    ready = 1'b1; enable = 1'b1; req = 16'h8421;
    step();
    req = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'(exp_idx[i])) begin
        n_bad++; $display("[TB] FAIL drain_idx%0d: got valid=%b idx=%0d, expected valid=1 idx=%0d", i, if0.out_valid, if0.out_idx, exp_idx[i]);
      end
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL drain_empty: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
  endtask

  // A stalled index holds even when a higher-priority request shows up.
  task automatic test_backpressure();
    ready = 1'b0; req = 16'h0008;
    step();
    req = 16'h0000;
    step();
    req = 16'h0001;
    step();
    req = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd3) begin
        n_bad++; $display("[TB] FAIL stall_hold%0d: got valid=%b idx=%0d, expected valid=1 idx=3", i, if0.out_valid, if0.out_idx);
      end
    end
    ready = 1'b1;
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd0) begin
      n_bad++; $display("[TB] FAIL stall_next: got valid=%b idx=%0d, expected valid=1 idx=0", if0.out_valid, if0.out_idx);
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL stall_empty: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
  endtask

  // After granting index 0, requests 0 and 1 come out 1,0 in round-robin
  // and 0,1 in fixed priority.
  task automatic test_round_robin();
    ready = 1'b1; req = 16'h0001;
    step();
    req = 16'h0000;
    step();
    n_cmp++;
    if (if1.out_valid !== 1'b1 || if1.out_idx !== 4'd0) begin
      n_bad++; $display("[TB] FAIL rr_first: got valid=%b idx=%0d, expected valid=1 idx=0", if1.out_valid, if1.out_idx);
    end
    step();
    req = 16'h0003;
    step();
    req = 16'h0000;
    step();
    n_cmp++;
    if (if1.out_valid !== 1'b1 || if1.out_idx !== 4'd1) begin
      n_bad++; $display("[TB] FAIL rr_grant_a: got valid=%b idx=%0d, expected valid=1 idx=1", if1.out_valid, if1.out_idx);
    end
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd0) begin
      n_bad++; $display("[TB] FAIL fp_grant_a: got valid=%b idx=%0d, expected valid=1 idx=0", if0.out_valid, if0.out_idx);
    end
    step();
    n_cmp++;
    if (if1.out_valid !== 1'b1 || if1.out_idx !== 4'd0) begin
      n_bad++; $display("[TB] FAIL rr_grant_b: got valid=%b idx=%0d, expected valid=1 idx=0", if1.out_valid, if1.out_idx);
    end
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd1) begin
      n_bad++; $display("[TB] FAIL fp_grant_b: got valid=%b idx=%0d, expected valid=1 idx=1", if0.out_valid, if0.out_idx);
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rr_empty: got valid=%b/%b, expected 0/0", if0.out_valid, if1.out_valid);
    end
  endtask

  // Duplicate request while pending pulses overflow once and merges; a
  // re-request in the accept cycle is not an overflow and is granted again.
  task automatic test_overflow();
    ready = 1'b0; req = 16'h0010;
    step();
    n_cmp++;
    if (ovf0 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL ovf_first_req: got %b, expected 0", ovf0);
    end
    step();
    req = 16'h0000;
    n_cmp++;
    if (ovf0 !== 1'b1 || pend0 !== 16'h0010) begin
      n_bad++; $display("[TB] FAIL ovf_pulse: got ovf=%b pending=%h, expected ovf=1 pending=0010", ovf0, pend0);
    end
    step();
    n_cmp++;
    if (ovf0 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL ovf_one_cycle: got %b, expected 0", ovf0);
    end
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd4) begin
      n_bad++; $display("[TB] FAIL ovf_grant: got valid=%b idx=%0d, expected valid=1 idx=4", if0.out_valid, if0.out_idx);
    end
    ready = 1'b1;
    step();
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL ovf_single_grant: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
    ready = 1'b0; req = 16'h0010;
    step();
    req = 16'h0000;
    step();
    ready = 1'b1; req = 16'h0010;
    step();
    req = 16'h0000;
    n_cmp++;
    if (ovf0 !== 1'b0 || pend0 !== 16'h0010 || if0.out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL regrant_accept: got ovf=%b pending=%h valid=%b, expected ovf=0 pending=0010 valid=0", ovf0, pend0, if0.out_valid);
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd4) begin
      n_bad++; $display("[TB] FAIL regrant_second: got valid=%b idx=%0d, expected valid=1 idx=4", if0.out_valid, if0.out_idx);
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL regrant_empty: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
  endtask

  // Disabled requests are ignored; clear flushes state over a new request.
  task automatic test_enable_clear();
    ready = 1'b0; enable = 1'b1; req = 16'h0006;
    step();
    req = 16'h0000;
    step();
    enable = 1'b0; req = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (pend0 !== 16'h0006 || ovf0 !== 1'b0) begin
        n_bad++; $display("[TB] FAIL enable_off%0d: got pending=%h ovf=%b, expected pending=0006 ovf=0", i, pend0, ovf0);
      end
    end
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.out_idx !== 4'd1) begin
      n_bad++; $display("[TB] FAIL enable_off_out: got valid=%b idx=%0d, expected valid=1 idx=1", if0.out_valid, if0.out_idx);
    end
    clear = 1'b1; enable = 1'b1; req = 16'h0001;
    step();
    clear = 1'b0; req = 16'h0000;
    n_cmp++;
    if (pend0 !== 16'h0000 || if0.out_valid !== 1'b0 || if0.out_idx !== 4'd0 || ovf0 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL clear_flush: got pending=%h valid=%b idx=%0d ovf=%b, expected 0000/0/0/0", pend0, if0.out_valid, if0.out_idx, ovf0);
    end
    step();
    n_cmp++;
    if (if0.out_valid !== 1'b0 || pend0 !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL clear_stays: got valid=%b pending=%h, expected valid=0 pending=0000", if0.out_valid, pend0);
    end
  endtask

  // Scenario sequence.
  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    req    = 16'h0000;
    ready  = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_drain();
    test_backpressure();
    test_round_robin();
    test_overflow();
    test_enable_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
